// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard for the decode stage.
// Tracks the destination tags of DEPTH in-flight post-decode stages and, for each
// decode read port, forwards the youngest matching result. When that result is
// not final yet (load-use), it raises a decode stall so the consumer is held.
// fwd_en, fwd_data and stall_id are combinational from the current tags and
// inputs, so they add no latency to decode. tag_valid, tag_addr and stall_count
// come straight from registers.
module fwd_scoreboard #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int ZERO_NOFWD = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_wb_en,
  input  logic [REG_AW-1:0]         id_wb_addr,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      pipe_advance,
  input  logic [DEPTH-1:0]          flush_mask,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  input  logic [DEPTH-1:0]          stage_data_ok,
  input  logic                      stat_clr,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [NUM_SRC-1:0]        fwd_en,
  output logic                      stall_id,
  output logic [DEPTH-1:0]          tag_valid,
  output logic [DEPTH*REG_AW-1:0]   tag_addr,
  output logic [15:0]               stall_count
);

  // Tag pipeline: entry 0 is EX, entry DEPTH-1 is WB.
  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          valid_d;
  logic [DEPTH*REG_AW-1:0]   addr_q;
  logic [DEPTH*REG_AW-1:0]   addr_d;
  logic [15:0]               stall_cnt_q;
  logic [15:0]               stall_cnt_d;

  // Match results per read port.
  logic [NUM_SRC-1:0]        found_s;
  logic [NUM_SRC-1:0]        hazard_s;
  logic [NUM_SRC-1:0]        fwd_en_s;
  logic [NUM_SRC*DATA_W-1:0] fwd_data_s;
  logic                      stall_s;

  // Youngest-match search: the first (lowest k) valid tag with the same address
  // decides the port; an older match never applies once a younger one is seen.
  always_comb begin
    found_s    = {NUM_SRC{1'b0}};
    hazard_s   = {NUM_SRC{1'b0}};
    fwd_en_s   = {NUM_SRC{1'b0}};
    fwd_data_s = {(NUM_SRC*DATA_W){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found_s[i] && src_used[i] && valid_q[k] &&
            (addr_q[k*REG_AW +: REG_AW] == src_addr[i*REG_AW +: REG_AW]) &&
            !((ZERO_NOFWD != 0) && (src_addr[i*REG_AW +: REG_AW] == {REG_AW{1'b0}}))) begin
          found_s[i] = 1'b1;
          if (stage_data_ok[k]) begin
            fwd_en_s[i]                       = 1'b1;
            fwd_data_s[i*DATA_W +: DATA_W]    = stage_data[k*DATA_W +: DATA_W];
          end else begin
            hazard_s[i]                       = 1'b1;
          end
        end else begin
          found_s[i] = found_s[i];
        end
      end
    end
  end

  // A hazard only stalls when decode actually holds an instruction.
  always_comb begin
    stall_s = id_valid & (|hazard_s);
  end

  // Next tag state: shift on advance (a stalled decode issues a bubble), then
  // apply flush_mask to the resulting entries, including the freshly issued one.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (pipe_advance) begin
      valid_d = {valid_q[DEPTH-2:0], (id_valid & id_wb_en & ~stall_s)};
      addr_d  = {addr_q[(DEPTH-1)*REG_AW-1:0], id_wb_addr};
    end else begin
      valid_d = valid_q;
    end
    valid_d = valid_d & ~flush_mask;
  end

  // Stall statistics: synchronous clear wins, otherwise count advancing stall cycles
  // and stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = 16'h0000;
    end else if (stall_s && pipe_advance && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset drops every in-flight tag at once so nothing stale forwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= {DEPTH{1'b0}};
      addr_q      <= {(DEPTH*REG_AW){1'b0}};
      stall_cnt_q <= 16'h0000;
    end else begin
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output drive.
  always_comb begin
    fwd_data    = fwd_data_s;
    fwd_en      = fwd_en_s;
    stall_id    = stall_s;
    tag_valid   = valid_q;
    tag_addr    = addr_q;
    stall_count = stall_cnt_q;
  end

endmodule
